// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types and sizing helpers for the shared-adder arbiter.
package adder_share_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam int DEF_WIDTH = 100;
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_req
);
    always_comb begin
        grant_id = '0;
        // scan from the far end so the nearest request to ptr wins last
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) grant_id = ID_W'(idx);
        end
        any_req = |req;
        grant = any_req ? NREQ'(1) << grant_id : '0;
    end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin shared WIDTH-bit adder with grant locking across
// multi-beat transactions, carry chaining and a one-entry output register.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int  WIDTH = DEF_WIDTH,
    parameter int  NREQ  = 2,
    localparam int ID_W  = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_last,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_last,
    output logic [ID_W-1:0]       rsp_id
);
    state_t          state, state_nxt;
    logic [ID_W-1:0] ptr, owner, grant_id, sel, sel_inc;
    logic [NREQ-1:0] grant;
    logic            any_req, can_accept, accept, carry, cin;
    logic [WIDTH:0]  total;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req(req_valid), .ptr(ptr), .grant(grant), .grant_id(grant_id), .any_req(any_req)
    );

    always_comb begin
        can_accept = !rsp_valid || rsp_ready;
        sel = (state == LOCKED) ? owner : grant_id;
        req_ready = (rst_n && can_accept) ? ((state == LOCKED) ? NREQ'(1) << owner : (any_req ? grant : '0)) : '0;
        accept = |(req_valid & req_ready);
        cin = (state == LOCKED) ? carry : req_cin[sel];
        total = {1'b0, req_a[sel*WIDTH +: WIDTH]} + {1'b0, req_b[sel*WIDTH +: WIDTH]} + (WIDTH+1)'(cin);
        sel_inc = (sel == ID_W'(NREQ - 1)) ? '0 : sel + 1'b1;
        state_nxt = accept ? (req_last[sel] ? IDLE : LOCKED) : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            carry     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_id    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                carry     <= total[WIDTH];
                rsp_sum   <= total[WIDTH-1:0];
                rsp_cout  <= total[WIDTH];
                rsp_last  <= req_last[sel];
                rsp_id    <= sel;
                rsp_valid <= 1'b1;
                owner     <= sel;
                if (req_last[sel]) ptr <= sel_inc;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed scenarios plus randomized multi-beat traffic checked
// against whole-number addition of the full-width operands.
module tb_adder_share_arbiter;
    localparam int W = 100;
    localparam int N = 2;
    localparam logic [W-1:0] ONES = '1;

    typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic last;} beat_t;
    typedef struct packed {logic [W-1:0] sum; logic cout; logic last;} exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_cin, req_last;
    logic [N*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_cout, rsp_last;
    logic [W-1:0]   rsp_sum;
    logic [0:0]     rsp_id;

    int checks = 0;
    int errors = 0;

    beat_t drv_q[N][$];
    exp_t  exp_q[N][$];
    logic  cin_r[N];

    adder_share_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_last(rsp_last), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3*W+1:0] msk(input int bits);
        logic [3*W+1:0] one = 1;
        return (one << bits) - one;
    endfunction

    function automatic logic [3*W+1:0] rnd();
        logic [3*W+1:0] v = '0;
        for (int k = 0; k < 10; k++) v = {v[3*W-31:0], $urandom()};
        return v;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // holds the beat on requester i until accepted; returns 1 time unit after the accepting edge
    task automatic beat(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic last);
        logic ok = 1'b0;
        req_valid[i] = 1'b1;
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i] = cin;
        req_last[i] = last;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = req_ready[i];
            @(posedge clk);
            #1;
        end
        check("accept_timeout", ok, 1);
        req_valid[i] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [W-1:0] sum, input logic cout, input logic last, input int id);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_sum"}, rsp_sum, sum);
        check({tag, "_cout"}, rsp_cout, cout);
        check({tag, "_last"}, rsp_last, last);
        check({tag, "_id"}, rsp_id, id);
    endtask

    initial begin
        logic [W-1:0] hold_sum;
        logic [0:0]   hold_id;
        rst_n = 1'b0;
        req_valid = '1;
        req_last = '1;
        req_cin = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        #12;
        check("rst_valid", rsp_valid, 0);
        check("rst_sum", rsp_sum, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_last", rsp_last, 0);
        check("rst_id", rsp_id, 0);
        check("rst_ready", req_ready, 0);
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        beat(0, ONES, 1, 0, 1);
        expect_rsp("single", 0, 1, 1, 0);
        req_valid = '1;
        req_last = '1;
        @(negedge clk);
        check("ptr_after_single", req_ready, 2'b10);
        req_valid = '0;
        @(posedge clk);
        #1;

        beat(1, ONES, 0, 1, 0);
        expect_rsp("chain1", 0, 1, 0, 1);
        beat(1, ONES, 0, 0, 0);
        expect_rsp("chain2", 0, 1, 0, 1);
        beat(1, ONES, 0, 0, 1);
        expect_rsp("chain3", 0, 1, 1, 1);

        do_reset();
        req_a = {W'(7), W'(5)};
        req_b = {W'(8), W'(6)};
        req_cin = '0;
        req_last = '1;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            expect_rsp("rr", (k % 2) ? W'(15) : W'(11), 0, 1, k % 2);
        end

        rsp_ready = 1'b0;
        hold_sum = rsp_sum;
        hold_id = rsp_id;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready", req_ready, 0);
            @(posedge clk);
            #1;
            check("bp_valid", rsp_valid, 1);
            check("bp_sum", rsp_sum, hold_sum);
            check("bp_id", rsp_id, hold_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_rsp("bp_resume", W'(11), 0, 1, 0);
        req_valid = '0;

        do_reset();
        beat(0, ONES, 1, 0, 0);
        expect_rsp("lock_b1", 0, 1, 0, 0);
        req_valid[1] = 1'b1;
        req_last[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lock_hold", req_ready[1], 0);
            @(posedge clk);
            #1;
        end
        beat(0, 0, 0, 0, 1);
        expect_rsp("lock_b2", 1, 0, 1, 0);
        @(negedge clk);
        check("lock_release", req_ready[1], 1);
        req_valid = '0;
        @(posedge clk);
        #1;

        do_reset();
        beat(0, ONES, 0, 1, 0);
        check("mid_b1_valid", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        do_reset();
        beat(0, ONES, 0, 0, 1);
        expect_rsp("mid_fresh", ONES, 0, 1, 0);

        random_phase();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic random_phase();
        logic [N-1:0]   acc;
        logic [3*W+1:0] a_full, b_full, part;
        beat_t          bt;
        exp_t           e;
        int             cyc = 0, pend = 0, id, prev_id = 0, lock_id = 0, n;
        bit             open = 0, lock_on = 0;
        do_reset();
        req_a = '0;
        req_b = '0;
        req_last = '0;
        req_cin = '0;
        while (cyc < 4000 && (cyc < 1500 || pend > 0)) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            check("acc_onehot", $countones(acc) <= 1, 1);
            if (lock_on)
                for (int j = 0; j < N; j++)
                    if (j != lock_id) check("rand_lock", req_ready[j], 0);
            for (int i = 0; i < N; i++)
                if (acc[i]) begin
                    lock_on = !req_last[i];
                    lock_id = i;
                end
            if (rsp_valid && rsp_ready) begin
                id = int'(rsp_id);
                if (open) check("contig", id, prev_id);
                check("rsp_expected", exp_q[id].size() > 0, 1);
                if (exp_q[id].size() > 0) begin
                    e = exp_q[id].pop_front();
                    check("rand_sum", rsp_sum, e.sum);
                    check("rand_cout", rsp_cout, e.cout);
                    check("rand_last", rsp_last, e.last);
                end
                open = !rsp_last;
                prev_id = id;
            end
            @(posedge clk);
            #1;
            pend = 0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) bt = drv_q[i].pop_front();
                if (drv_q[i].size() == 0 && cyc < 1500 && $urandom_range(3) == 0) begin
                    n = $urandom_range(3, 1);
                    a_full = rnd() & msk(n * W);
                    b_full = ($urandom_range(3) == 0) ? (~a_full & msk(n * W)) : (rnd() & msk(n * W));
                    cin_r[i] = 1'($urandom_range(1));
                    for (int k = 0; k < n; k++) begin
                        drv_q[i].push_back({a_full[k*W +: W], b_full[k*W +: W], k == n - 1});
                        part = (a_full & msk((k + 1) * W)) + (b_full & msk((k + 1) * W)) + (3*W+2)'(cin_r[i]);
                        exp_q[i].push_back({part[k*W +: W], part[(k + 1) * W], k == n - 1});
                    end
                end
                if (drv_q[i].size() == 0) req_valid[i] = 1'b0;
                else if (!(req_valid[i] && !acc[i])) req_valid[i] = ($urandom_range(3) != 0);
                if (drv_q[i].size() > 0) begin
                    bt = drv_q[i][0];
                    req_a[i*W +: W] = bt.a;
                    req_b[i*W +: W] = bt.b;
                    req_last[i] = bt.last;
                    req_cin[i] = cin_r[i];
                end
                pend += drv_q[i].size() + exp_q[i].size();
            end
            rsp_ready = ($urandom_range(3) != 0);
            cyc++;
        end
        check("drain_left", pend, 0);
    endtask
endmodule
